// File: rtl/cent_vram_pkg.sv
// Shared defaults and the owner tag for the video RAM arbiter slice.
package cent_vram_pkg;

  localparam int unsigned AW_DEF          = 10;
  localparam int unsigned DW_DEF          = 8;
  localparam int unsigned MAX_VID_RUN_DEF = 4;
  localparam int unsigned LEN_W           = 6;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } owner_t;

endpackage

// File: rtl/cent_vram_burst.sv
// Video line-fetch burst sequencer: latches base/length, walks the issue index, tracks busy.
module cent_vram_burst
  import cent_vram_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [LEN_W-1:0] len,
  input  logic             issue,
  output logic             busy,
  output logic             pending,
  output logic [AW-1:0]    addr,
  output logic [LEN_W-1:0] idx
);

  logic [AW-1:0]    base_q;
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      len_q   <= '0;
      idx     <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
    end else if (start && !busy && len != '0) begin
      base_q  <= base;
      len_q   <= len;
      idx     <= '0;
      pending <= 1'b1;
      busy    <= 1'b1;
    end else begin
      if (issue && pending) begin
        if (idx == len_q - LEN_W'(1)) pending <= 1'b0;
        else                          idx     <= idx + LEN_W'(1);
      end
      // busy with nothing left to issue is exactly the last write-back cycle
      if (busy && !pending) busy <= 1'b0;
    end
  end

  assign addr = base_q + AW'(idx);

endmodule

// File: rtl/cent_vram_arb.sv
// Single-port video RAM arbiter: video bursts have priority, CPU wait bounded by MAX_VID_RUN.
module cent_vram_arb
  import cent_vram_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned MAX_VID_RUN = MAX_VID_RUN_DEF
) (
  input  logic             clk_vga,
  input  logic             reset,
  input  logic             vid_start,
  input  logic [AW-1:0]    vid_base,
  input  logic [5:0]       vid_len,
  output logic             vid_busy,
  output logic             vid_wr,
  output logic [5:0]       vid_waddr,
  output logic [DW-1:0]    vid_wdata,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic             cpu_ack,
  output logic [DW-1:0]    cpu_rdata,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [DW-1:0]    ram_wdata,
  input  logic [DW-1:0]    ram_rdata
);

  localparam int unsigned RW = $clog2(MAX_VID_RUN + 1);

  owner_t           own_q;
  logic             own_we_q;
  logic [RW-1:0]    run_cnt;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic [5:0]       idx_q;
  logic             vid_pend;
  logic             cpu_elig;
  logic             vid_issue;
  logic             cpu_issue;
  logic [AW-1:0]    burst_addr;
  logic [LEN_W-1:0] burst_idx;

  cent_vram_burst #(.AW(AW)) u_burst (
    .clk     (clk_vga),
    .rst     (reset),
    .start   (vid_start),
    .base    (vid_base),
    .len     (vid_len),
    .issue   (vid_issue),
    .busy    (vid_busy),
    .pending (vid_pend),
    .addr    (burst_addr),
    .idx     (burst_idx)
  );

  // CPU is ineligible in its own ack cycle, which enforces the 2-cycle spacing
  always_comb begin
    cpu_elig  = !reset && cpu_req && (own_q != OWN_CPU);
    vid_issue = 1'b0;
    cpu_issue = 1'b0;
    if (vid_pend && cpu_elig) begin
      if (run_cnt == RW'(MAX_VID_RUN)) cpu_issue = 1'b1;
      else                             vid_issue = 1'b1;
    end else begin
      vid_issue = vid_pend;
      cpu_issue = cpu_elig;
    end
  end

  assign ram_we    = cpu_issue && cpu_we;
  assign ram_addr  = cpu_issue ? cpu_addr : (vid_issue ? burst_addr : addr_q);
  assign ram_wdata = cpu_issue ? cpu_wdata : wdata_q;

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      own_q    <= OWN_NONE;
      own_we_q <= 1'b0;
      run_cnt  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      idx_q    <= '0;
    end else begin
      own_q    <= cpu_issue ? OWN_CPU : (vid_issue ? OWN_VID : OWN_NONE);
      own_we_q <= cpu_issue && cpu_we;
      if (cpu_issue || vid_issue) addr_q  <= ram_addr;
      if (cpu_issue)              wdata_q <= cpu_wdata;
      if (vid_issue)              idx_q   <= burst_idx;
      if (own_q == OWN_CPU && !own_we_q) rdata_q <= ram_rdata;
      if (cpu_issue || !cpu_elig) run_cnt <= '0;
      else if (vid_issue)         run_cnt <= run_cnt + RW'(1);
    end
  end

  assign vid_wr    = (own_q == OWN_VID);
  assign vid_waddr = idx_q;
  assign vid_wdata = vid_wr ? ram_rdata : '0;
  assign cpu_ack   = (own_q == OWN_CPU);
  assign cpu_rdata = (cpu_ack && !own_we_q) ? ram_rdata : rdata_q;

endmodule
